// File: rtl/ram_sync_bist.sv
// ram_sync_bist: write/read-back self-test engine for a single-port ram_sync.
// Fills every word with (seed + addr), optionally inverted, reads each word
// back one cycle later through the RAM's registered read port, and reports
// a saturating mismatch count and the first failing address.
module ram_sync_bist #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  invert,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   MAX_FAILS = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic                    invert_q;
    logic                    exp_valid;
    logic [ADDR_WIDTH-1:0]   exp_addr;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic                    mismatch;
    logic [ADDR_WIDTH:0]     fail_count_nxt;

    // Test pattern is a pure function of the address so nothing is stored.
    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [DATA_WIDTH-1:0] s,
        input logic                  inv,
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [DATA_WIDTH-1:0] p;
        p = s + DATA_WIDTH'(a);
        return inv ? ~p : p;
    endfunction

    // Compare the returning read word and form the saturated fail count.
    always_comb begin
        mismatch       = exp_valid && (ram_rdata != exp_data);
        fail_count_nxt = fail_count;
        if (mismatch && (fail_count < MAX_FAILS)) begin
            fail_count_nxt = fail_count + 1'b1;
        end
    end

    // Sequencer: fill, read back with a one-stage expectation pipe, drain, report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            seed_q          <= '0;
            invert_q        <= 1'b0;
            exp_valid       <= 1'b0;
            exp_addr        <= '0;
            exp_data        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            ram_addr        <= '0;
            ram_data        <= '0;
            ram_cs          <= 1'b0;
            ram_we          <= 1'b0;
            ram_oe          <= 1'b0;
        end else begin
            done      <= 1'b0;
            exp_valid <= 1'b0;
            if (exp_valid) begin
                fail_count <= fail_count_nxt;
                if (mismatch && (fail_count == '0)) begin
                    first_fail_addr <= exp_addr;
                end
            end
            case (state)
                IDLE: begin
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                    ram_oe <= 1'b0;
                    if (start) begin
                        seed_q          <= seed;
                        invert_q        <= invert;
                        fail_count      <= '0;
                        first_fail_addr <= '0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        cnt             <= '0;
                        state           <= WRITE;
                        ram_cs          <= 1'b1;
                        ram_we          <= 1'b1;
                        ram_addr        <= '0;
                        ram_data        <= pattern(seed, invert, '0);
                    end
                end
                WRITE: begin
                    if (cnt == LAST_ADDR) begin
                        state    <= READ;
                        cnt      <= '0;
                        ram_we   <= 1'b0;
                        ram_oe   <= 1'b1;
                        ram_addr <= '0;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        ram_addr <= cnt + 1'b1;
                        ram_data <= pattern(seed_q, invert_q, cnt + 1'b1);
                    end
                end
                READ: begin
                    exp_valid <= 1'b1;
                    exp_addr  <= cnt;
                    exp_data  <= pattern(seed_q, invert_q, cnt);
                    if (cnt == LAST_ADDR) begin
                        state  <= DRAIN;
                        ram_cs <= 1'b0;
                        ram_oe <= 1'b0;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        ram_addr <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (fail_count_nxt == '0);
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sync_bist.sv
// tb_ram_sync_bist: drives ram_sync_bist against a behavioural RAM with
// injectable stuck bits and checks every cycle against a phase-based model.
module tb_ram_sync_bist;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed;
    logic          invert;
    logic          busy, done, pass;
    logic [AW:0]   fail_count;
    logic [AW-1:0] first_fail_addr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_cs, ram_we, ram_oe;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem      [DEPTH];
    logic [DW-1:0] or_mask  [DEPTH];
    logic [DW-1:0] and_mask [DEPTH];

    int tests_run = 0;
    int failures  = 0;

    // Model: t = clock edges since the edge that accepted start (-1 after reset).
    int          t = -1;
    logic [DW-1:0] m_seed;
    logic        m_inv;
    int          r_fc, r_ffa;

    always #5 clk = ~clk;

    ram_sync_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .invert(invert),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_addr(first_fail_addr), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_rdata(ram_rdata)
    );

    // Behavioural RAM: synchronous write, registered read, stuck bits on read.
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        if (ram_cs && ram_oe && !ram_we)
            ram_rdata <= (mem[ram_addr] | or_mask[ram_addr]) & and_mask[ram_addr];
    end

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input logic inv, input int a);
        logic [DW-1:0] p;
        p = s + DW'(a);
        return inv ? ~p : p;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (phase %0d)", name, actual, expected, t);
        end
    endtask

    // Model advance: accept start only when idle, snapshot expected results.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                t = -1;
            end else if ((t < 0 || t >= 18) && start) begin
                t      = 0;
                m_seed = seed;
                m_inv  = invert;
                r_fc   = 0;
                r_ffa  = 0;
                for (int a = 0; a < DEPTH; a++) begin
                    logic [DW-1:0] e, g;
                    e = pat(m_seed, m_inv, a);
                    g = (e | or_mask[a]) & and_mask[a];
                    if (g != e) begin
                        if (r_fc == 0) r_ffa = a;
                        if (r_fc < DEPTH) r_fc++;
                    end
                end
            end else if (t >= 0) begin
                t = t + 1;
            end
        end
    end

    // Per-cycle compare of every output against the phase model.
    initial begin
        forever begin
            @(negedge clk);
            begin
                logic e_busy, e_done, e_cs, e_we, e_oe;
                int   e_addr;
                e_busy = (t >= 0 && t <= 16);
                e_done = (t == 17);
                e_cs   = (t >= 0 && t <= 15);
                e_we   = (t >= 0 && t <= 7);
                e_oe   = (t >= 8 && t <= 15);
                e_addr = (t <= 7) ? t : t - 8;
                checkOutput("busy", 64'(busy), 64'(e_busy));
                checkOutput("done", 64'(done), 64'(e_done));
                checkOutput("ram_cs", 64'(ram_cs), 64'(e_cs));
                checkOutput("ram_we", 64'(ram_we), 64'(e_we));
                checkOutput("ram_oe", 64'(ram_oe), 64'(e_oe));
                checkOutput("we_oe_exclusive", 64'(ram_we && ram_oe), 64'(0));
                if (e_cs) checkOutput("ram_addr", 64'(ram_addr), 64'(e_addr));
                if (e_we) checkOutput("ram_data", 64'(ram_data), 64'(pat(m_seed, m_inv, t)));
                if (t < 0) begin
                    checkOutput("pass_rst", 64'(pass), 64'(0));
                    checkOutput("fail_count_rst", 64'(fail_count), 64'(0));
                    checkOutput("first_fail_rst", 64'(first_fail_addr), 64'(0));
                end else if (t >= 17) begin
                    checkOutput("pass", 64'(pass), 64'(r_fc == 0));
                    checkOutput("fail_count", 64'(fail_count), 64'(r_fc));
                    checkOutput("first_fail_addr", 64'(first_fail_addr), 64'(r_ffa));
                end else begin
                    checkOutput("pass_during_run", 64'(pass), 64'(0));
                end
            end
        end
    end

    // One full test: pulse start, scramble inputs, optionally poke start while busy.
    task automatic applyStimulus(input logic [DW-1:0] s, input logic inv, input bit poke, output int latency);
        @(negedge clk);
        seed   = s;
        invert = inv;
        start  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        seed    = $urandom;
        invert  = 1'($urandom_range(0, 1));
        latency = 0;
        while (!done && latency < 40) begin
            @(negedge clk);
            latency++;
            start = poke && (latency == 3 || latency == 10);
        end
        start = 1'b0;
        if (!done) checkOutput("done_timeout", 64'(0), 64'(1));
        @(negedge clk);
    endtask

    task automatic clearFaults();
        for (int a = 0; a < DEPTH; a++) begin
            or_mask[a]  = '0;
            and_mask[a] = '1;
        end
    endtask

    initial begin
        int lat;
        int dones;
        rst    = 1'b1;
        start  = 1'b0;
        seed   = '0;
        invert = 1'b0;
        clearFaults();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_fail_count", 64'(fail_count), 64'(0));

        // Clean run with literal expectations.
        applyStimulus(32'h0000_0010, 1'b0, 1'b0, lat);
        checkOutput("clean_latency", 64'(lat + 1), 64'(18));
        checkOutput("clean_pass", 64'(pass), 64'(1));
        checkOutput("clean_fail_count", 64'(fail_count), 64'(0));
        checkOutput("clean_first_fail", 64'(first_fail_addr), 64'(0));
        for (int a = 0; a < DEPTH; a++)
            checkOutput("clean_mem", 64'(mem[a]), 64'(32'h10 + a));

        // Wrap and inversion.
        applyStimulus(32'hFFFF_FFFE, 1'b0, 1'b0, lat);
        checkOutput("wrap_mem2", 64'(mem[2]), 64'(32'h0000_0000));
        checkOutput("wrap_pass", 64'(pass), 64'(1));
        applyStimulus(32'hFFFF_FFFE, 1'b1, 1'b0, lat);
        checkOutput("invert_mem2", 64'(mem[2]), 64'(32'hFFFF_FFFF));
        checkOutput("invert_pass", 64'(pass), 64'(1));

        // Stuck bit 0 at addresses 5 and 6.
        or_mask[5] = 32'h1;
        or_mask[6] = 32'h1;
        applyStimulus(32'h0, 1'b0, 1'b0, lat);
        checkOutput("stuck0_fail_count", 64'(fail_count), 64'(1));
        checkOutput("stuck0_first_fail", 64'(first_fail_addr), 64'(6));
        checkOutput("stuck0_pass", 64'(pass), 64'(0));

        // Stuck bit 3 everywhere saturates the count.
        for (int a = 0; a < DEPTH; a++) or_mask[a] = 32'h8;
        applyStimulus(32'h0, 1'b0, 1'b0, lat);
        checkOutput("stuck3_fail_count", 64'(fail_count), 64'(8));
        checkOutput("stuck3_first_fail", 64'(first_fail_addr), 64'(0));
        checkOutput("stuck3_pass", 64'(pass), 64'(0));
        clearFaults();

        // Start pulses while busy are ignored.
        applyStimulus(32'h0000_0010, 1'b0, 1'b1, lat);
        checkOutput("poke_latency", 64'(lat + 1), 64'(18));
        checkOutput("poke_pass", 64'(pass), 64'(1));
        repeat (3) @(negedge clk);
        checkOutput("poke_no_restart", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of the read phase.
        @(negedge clk);
        seed  = 32'h1234_5678;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_busy", 64'(busy), 64'(0));
        checkOutput("arst_done", 64'(done), 64'(0));
        checkOutput("arst_cs", 64'(ram_cs), 64'(0));
        checkOutput("arst_oe", 64'(ram_oe), 64'(0));
        checkOutput("arst_addr", 64'(ram_addr), 64'(0));
        checkOutput("arst_data", 64'(ram_data), 64'(0));
        checkOutput("arst_fail_count", 64'(fail_count), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        applyStimulus($urandom, 1'($urandom_range(0, 1)), 1'b0, lat);
        checkOutput("after_arst_pass", 64'(pass), 64'(1));

        // Start held high gives back-to-back runs.
        @(negedge clk);
        seed  = $urandom;
        start = 1'b1;
        dones = 0;
        repeat (57) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        checkOutput("back_to_back_dones", 64'(dones), 64'(3));
        repeat (25) @(negedge clk);

        // Randomized runs with random stuck-at-1/stuck-at-0 faults.
        for (int n = 0; n < 20; n++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int r;
                r = $urandom_range(0, 3);
                or_mask[a]  = (r == 0) ? (32'd1 << $urandom_range(0, 31)) : '0;
                and_mask[a] = (r == 1) ? ~(32'd1 << $urandom_range(0, 31)) : '1;
            end
            applyStimulus($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    // Global time bound so the bench cannot hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/ram_sync_bist.md
Name: ram_sync_bist

Overview:
- Initiator/test engine for the single-port synchronous RAM `ram_sync`; it drives the RAM's address, data, chip-select, write-enable and output-enable ports.
- On a start pulse it fills every RAM word with a deterministic pattern, reads all words back, compares each one and reports pass/fail with diagnostics.
- Sits between the SoC control logic and a `ram_sync` instance.
- Used for power-on memory self-test and for authentication-platform RAM integrity checks.

Parameters:
- ADDR_WIDTH, 3, RAM address width.
- DATA_WIDTH, 32, RAM word width.
- DEPTH, 8, number of words tested (addresses 0..DEPTH-1), DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a test; sampled only in IDLE.
- seed  in  DATA_WIDTH  pattern seed; captured when start is accepted.
- invert  in  1  pattern polarity; captured when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the test completes.
- pass  out  1  1 when fail_count==0; valid from done, held until next start.
- fail_count  out  ADDR_WIDTH+1  number of mismatching words; saturates at DEPTH.
- first_fail_addr  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_data  out  DATA_WIDTH  to RAM data (write data).
- ram_cs  out  1  to RAM cs.
- ram_we  out  1  to RAM we.
- ram_oe  out  1  to RAM oe.
- ram_rdata  in  DATA_WIDTH  from RAM ram_output.

Behaviour:
- RAM contract: a write occurs at a posedge when cs&we are high. A read is registered: with cs&oe&!we high and addr A at posedge N, ram_rdata = mem[A] after posedge N, so it is sampled at posedge N+1.
- Pattern: P(a) = (seed_q + a) mod 2**DATA_WIDTH, with `a` zero-extended. If invert_q is set, the pattern is ~P(a). The pattern is recomputed from the address in both phases; no pattern storage.
- All outputs are registered.
- Reset (asynchronous, any state) forces:
  - state = IDLE;
  - busy = done = 0, pass = 0, fail_count = 0, first_fail_addr = 0;
  - ram_cs = ram_we = ram_oe = 0, ram_addr = 0, ram_data = 0.
  - Reset mid-test aborts immediately; RAM contents are undefined afterwards.
- States:
  - IDLE: RAM strobes low. If start is high: capture seed/invert, clear fail_count/first_fail_addr/pass, go to WRITE with addr counter = 0.
  - WRITE: ram_cs=1, ram_we=1, ram_oe=0, ram_addr=cnt, ram_data=pattern(cnt). Hold each address one cycle. After address DEPTH-1, go to READ with cnt = 0. No idle gap.
  - READ: ram_cs=1, ram_we=0, ram_oe=1, ram_addr=cnt. Expected value and address are pipelined one stage (exp_valid, exp_addr, exp_data). After address DEPTH-1, go to DRAIN.
  - DRAIN: strobes low; perform the compare for the last read; go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, pass = (final fail_count==0); go to IDLE.
- Compare (every cycle exp_valid is high):
  - If ram_rdata != exp_data: fail_count += 1, saturating at DEPTH.
  - If it is the first mismatch of the run: first_fail_addr = exp_addr.
- Timing: start sampled at posedge 0, so WRITE runs cycles 1..DEPTH, READ runs DEPTH+1..2*DEPTH, DRAIN is 2*DEPTH+1, and done is high in cycle 2*DEPTH+2. For DEPTH=8, done follows start by 18 cycles.
- busy is high in WRITE/READ/DRAIN and low in IDLE and DONE.
- start while not in IDLE (including the DONE cycle) is ignored; no queueing.
- start held high continuously in IDLE starts back-to-back tests, one per return to IDLE.
- Counter wrap: cnt is ADDR_WIDTH wide. The transition is decided on cnt==DEPTH-1, never on overflow, so DEPTH == 2**ADDR_WIDTH works.
- Pattern arithmetic wraps modulo 2**DATA_WIDTH.

Test Plan:
- Clean run: seed=32'h0000_0010, invert=0, good RAM model → writes 0x10..0x17 to addresses 0..7; done in cycle 18; pass=1, fail_count=0, first_fail_addr=0.
- Inverted pattern: seed=32'hFFFF_FFFE, invert=0 then invert=1 → address 2 holds 0x0000_0000 (wrap) then 0xFFFF_FFFF; pass=1 both runs.
- Fault injection: RAM model with bit 0 stuck-at-1 at addresses 5 and 6, seed=0 → fail_count=1 (addr 5 expects 0x5, reads 0x5, so no fail; addr 6 reads 0x7), first_fail_addr=6, pass=0. Second case, seed=0 with stuck bit 3 at every address → fail_count=8 (saturated at DEPTH), first_fail_addr=0.
- Strobe/protocol check: monitor asserts ram_we && ram_oe is never high together; ram_cs is low in IDLE/DRAIN/DONE; exactly 8 write cycles then 8 read cycles with ascending addresses.
- Start while busy: pulse start at cycles 3 and 10 of a run → ignored; a single done pulse; results match a clean run.
- Async reset mid-READ: assert rst between clock edges at cycle 12 → all outputs 0 immediately (before the next edge); a following start runs a full test with correct results.
